// File: rtl/reg_grp_decoder_if.sv
// +--------------------------------------------------------------------------+
// | reg_grp_decoder_if : upstream register request/ack bus                   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface reg_grp_decoder_if #(
  parameter int ADDR_WIDTH = 7
);
  logic                  reg_req;
  logic                  reg_rd_wr_L;
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic [31:0]           reg_wr_data;
  logic                  reg_ack;
  logic [31:0]           reg_rd_data;

  modport master (
    output reg_req, reg_rd_wr_L, reg_addr, reg_wr_data,
    input  reg_ack, reg_rd_data
  );

  modport slave (
    input  reg_req, reg_rd_wr_L, reg_addr, reg_wr_data,
    output reg_ack, reg_rd_data
  );
endinterface

`default_nettype wire

// File: rtl/reg_grp_decoder.sv
// +--------------------------------------------------------------------------+
// | reg_grp_decoder : fans one register bus out to 2**NUM_SLAVES_LOG2 blocks |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module reg_grp_decoder #(
  parameter int SUB_ADDR_WIDTH  = 5,
  parameter int NUM_SLAVES_LOG2 = 2,
  parameter int TIMEOUT         = 16,
  localparam int NUM_SLAVES     = 2 ** NUM_SLAVES_LOG2
) (
  input  logic                        clk,
  input  logic                        reset,
  reg_grp_decoder_if.slave            bus,
  output logic [NUM_SLAVES-1:0]       local_reg_req_o,
  output logic                        local_reg_rd_wr_L_o,
  output logic [SUB_ADDR_WIDTH-1:0]   local_reg_addr_o,
  output logic [31:0]                 local_reg_wr_data_o,
  input  logic [NUM_SLAVES-1:0]       local_reg_ack_i,
  input  logic [32*NUM_SLAVES-1:0]    local_reg_rd_data_i,
  output logic [7:0]                  timeout_cnt_o
);

  localparam int          ADDR_W        = NUM_SLAVES_LOG2 + SUB_ADDR_WIDTH;
  localparam logic [31:0] c_TIMEOUT_DATA = 32'hDEAD_DEAD;
  localparam logic [7:0]  c_WAIT_LAST    = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic                        req_prev_q, req_prev_d;
  logic                        armed_q, armed_d;
  logic [NUM_SLAVES_LOG2-1:0]  sel_q, sel_d;
  logic [SUB_ADDR_WIDTH-1:0]   sub_addr_q, sub_addr_d;
  logic                        rd_wr_L_q, rd_wr_L_d;
  logic [31:0]                 wr_data_q, wr_data_d;
  logic [7:0]                  wait_cnt_q, wait_cnt_d;
  logic [31:0]                 rd_data_q, rd_data_d;
  logic                        ack_q, ack_d;
  logic [7:0]                  timeout_cnt_q, timeout_cnt_d;

  logic [31:0] w_slice [NUM_SLAVES];
  logic        w_start;
  logic        w_ack;

  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slice
    assign w_slice[gi] = local_reg_rd_data_i[32*gi +: 32];
  end

  // armed_q blocks a start until reg_req has been seen low after reset.
  assign w_start = bus.reg_req & ~req_prev_q & armed_q;
  assign w_ack   = local_reg_ack_i[sel_q];

  always_comb begin
    state_d         = state_q;
    req_prev_d      = bus.reg_req;
    armed_d         = armed_q | ~bus.reg_req;
    sel_d           = sel_q;
    sub_addr_d      = sub_addr_q;
    rd_wr_L_d       = rd_wr_L_q;
    wr_data_d       = wr_data_q;
    wait_cnt_d      = wait_cnt_q;
    rd_data_d       = rd_data_q;
    ack_d           = 1'b0;
    timeout_cnt_d   = timeout_cnt_q;
    local_reg_req_o = '0;

    case (state_q)
      IDLE: begin
        if (w_start) begin
          state_d    = WAIT;
          sel_d      = bus.reg_addr[ADDR_W-1 -: NUM_SLAVES_LOG2];
          sub_addr_d = bus.reg_addr[SUB_ADDR_WIDTH-1:0];
          rd_wr_L_d  = bus.reg_rd_wr_L;
          wr_data_d  = bus.reg_wr_data;
          wait_cnt_d = '0;
        end
      end
      WAIT: begin
        local_reg_req_o[sel_q] = 1'b1;
        if (w_ack) begin
          rd_data_d = w_slice[sel_q];
          ack_d     = bus.reg_req;
          state_d   = DONE;
        end else if (wait_cnt_q == c_WAIT_LAST) begin
          rd_data_d = c_TIMEOUT_DATA;
          ack_d     = bus.reg_req;
          state_d   = DONE;
          if (timeout_cnt_q != 8'hFF) timeout_cnt_d = timeout_cnt_q + 8'd1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      DONE: begin
        if (!bus.reg_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      req_prev_q    <= 1'b0;
      armed_q       <= ~bus.reg_req;
      sel_q         <= '0;
      sub_addr_q    <= '0;
      rd_wr_L_q     <= 1'b0;
      wr_data_q     <= '0;
      wait_cnt_q    <= '0;
      rd_data_q     <= '0;
      ack_q         <= 1'b0;
      timeout_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      req_prev_q    <= req_prev_d;
      armed_q       <= armed_d;
      sel_q         <= sel_d;
      sub_addr_q    <= sub_addr_d;
      rd_wr_L_q     <= rd_wr_L_d;
      wr_data_q     <= wr_data_d;
      wait_cnt_q    <= wait_cnt_d;
      rd_data_q     <= rd_data_d;
      ack_q         <= ack_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end

  assign bus.reg_ack          = ack_q;
  assign bus.reg_rd_data      = rd_data_q;
  assign local_reg_rd_wr_L_o  = rd_wr_L_q;
  assign local_reg_addr_o     = sub_addr_q;
  assign local_reg_wr_data_o  = wr_data_q;
  assign timeout_cnt_o        = timeout_cnt_q;

endmodule

`default_nettype wire
